// File: rtl/inject_sequencer_pkg.sv
// Shared micro-opcodes and state encoding for the control-flow inject sequencer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package inject_sequencer_pkg;

    localparam logic [15:0] OP_NOP        = 16'h0000;
    localparam logic [15:0] OP_PUSH_PC_HI = 16'h0001;
    localparam logic [15:0] OP_PUSH_PC_LO = 16'h0002;
    localparam logic [15:0] OP_PUSH_CCR   = 16'h0003;
    localparam logic [15:0] OP_POP_CCR    = 16'h0004;
    localparam logic [15:0] OP_POP_PC_LO  = 16'h0005;
    localparam logic [15:0] OP_POP_PC_HI  = 16'h0006;

    localparam int STEP_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALL = 3'd1,
        ST_RET  = 3'd2,
        ST_INT  = 3'd3,
        ST_RTI  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/inject_sequencer_if.sv
// Bundle between decode/fetch and the inject sequencer.
// Latency: n/a (wires only).
// Backpressure: stall_in freezes the sequencer; requests are held by decode until served.
// Ports: requests (call/ret/rti, int_flag, rdst_value, stall_in) flow master->slave;
//        injection/PC controls (inj_*, pc_*, int_ack, busy) flow slave->master.
interface inject_sequencer_if #(
    parameter int IW  = 16,
    parameter int PCW = 32
);
    logic           call_req;
    logic           ret_req;
    logic           rti_req;
    logic           int_flag;
    logic [15:0]    rdst_value;
    logic           stall_in;
    logic           inj_valid;
    logic [IW-1:0]  inj_instr;
    logic           pc_hold;
    logic           pc_load;
    logic [PCW-1:0] pc_load_value;
    logic           int_ack;
    logic           busy;

    // Decode/fetch side.
    modport master (
        output call_req, ret_req, rti_req, int_flag, rdst_value, stall_in,
        input  inj_valid, inj_instr, pc_hold, pc_load, pc_load_value, int_ack, busy
    );

    // Sequencer side.
    modport slave (
        input  call_req, ret_req, rti_req, int_flag, rdst_value, stall_in,
        output inj_valid, inj_instr, pc_hold, pc_load, pc_load_value, int_ack, busy
    );
endinterface

// File: rtl/inject_sequencer_uop_rom.sv
// Micro-op table: maps (state, step) to the injected instruction and step controls.
// Latency: combinational.
// Backpressure: none; the caller freezes state/step to hold outputs.
// Ports: state_i/step_i in; inj_valid_o, inj_instr_o, pc_load_o, last_step_o out.
module seq_uop_rom
    import inject_sequencer_pkg::*;
(
    input  seq_state_t        state_i,
    input  logic [STEP_W-1:0] step_i,
    output logic              inj_valid_o,
    output logic [15:0]       inj_instr_o,
    output logic              pc_load_o,
    output logic              last_step_o
);

    // Out-of-range steps decode as the final step so a corrupted counter
    // always drains back to IDLE instead of locking up.
    always_comb begin
        inj_valid_o = 1'b0;
        inj_instr_o = OP_NOP;
        pc_load_o   = 1'b0;
        last_step_o = 1'b0;
        case (state_i)
            ST_CALL: begin
                case (step_i)
                    3'd0:    begin inj_valid_o = 1'b1; inj_instr_o = OP_PUSH_PC_HI; end
                    3'd1:    begin inj_valid_o = 1'b1; inj_instr_o = OP_PUSH_PC_LO; end
                    default: begin pc_load_o = 1'b1; last_step_o = 1'b1; end
                endcase
            end
            ST_RET: begin
                inj_valid_o = 1'b1;
                case (step_i)
                    3'd0:    inj_instr_o = OP_POP_PC_LO;
                    3'd1:    inj_instr_o = OP_POP_PC_HI;
                    3'd2:    inj_instr_o = OP_NOP;
                    default: last_step_o = 1'b1;
                endcase
            end
            ST_INT: begin
                case (step_i)
                    3'd0:    begin inj_valid_o = 1'b1; inj_instr_o = OP_PUSH_PC_HI; end
                    3'd1:    begin inj_valid_o = 1'b1; inj_instr_o = OP_PUSH_PC_LO; end
                    3'd2:    begin inj_valid_o = 1'b1; inj_instr_o = OP_PUSH_CCR; end
                    default: begin pc_load_o = 1'b1; last_step_o = 1'b1; end
                endcase
            end
            ST_RTI: begin
                inj_valid_o = 1'b1;
                case (step_i)
                    3'd0:    inj_instr_o = OP_POP_CCR;
                    3'd1:    inj_instr_o = OP_POP_PC_LO;
                    3'd2:    inj_instr_o = OP_POP_PC_HI;
                    3'd3:    inj_instr_o = OP_NOP;
                    default: last_step_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/inject_sequencer.sv
// Arbitrated sequencer for CALL/RET/RTI/interrupt entry driving fetch injection and PC load.
// Latency: request sampled at edge N, first step outputs in cycle N+1; int edge -> INT step 0 two cycles after.
// Backpressure: stall_in freezes state, step, target and outputs; int edge capture keeps running.
// Ports: clk, reset (sync, active-low); bus (slave modport) carries requests in and controls out.
module inject_sequencer
    import inject_sequencer_pkg::*;
#(
    parameter int             IW         = 16,
    parameter int             PCW        = 32,
    parameter logic [PCW-1:0] INT_VECTOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    inject_sequencer_if.slave bus
);

    seq_state_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [15:0]       target_q, target_d;
    logic              int_flag_q;
    logic              int_pending_q, int_pending_d;

    logic              rom_inj_valid;
    logic [15:0]       rom_inj_instr;
    logic              rom_pc_load;
    logic              rom_last_step;

    seq_uop_rom u_rom (
        .state_i     (state_q),
        .step_i      (step_q),
        .inj_valid_o (rom_inj_valid),
        .inj_instr_o (rom_inj_instr),
        .pc_load_o   (rom_pc_load),
        .last_step_o (rom_last_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            step_q        <= '0;
            target_q      <= '0;
            int_flag_q    <= 1'b0;
            int_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            target_q      <= target_d;
            int_flag_q    <= bus.int_flag;
            int_pending_q <= int_pending_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        step_d        = step_q;
        target_d      = target_q;
        int_pending_d = int_pending_q;

        // Rising edge sets pending; edges while already pending are absorbed.
        if (bus.int_flag && !int_flag_q) begin
            int_pending_d = 1'b1;
        end

        if (!bus.stall_in) begin
            if (state_q == ST_IDLE) begin
                step_d = '0;
                // Decode requests win; a pending interrupt waits for a quiet IDLE cycle.
                if (bus.call_req) begin
                    state_d  = ST_CALL;
                    target_d = bus.rdst_value;
                end else if (bus.ret_req) begin
                    state_d = ST_RET;
                end else if (bus.rti_req) begin
                    state_d = ST_RTI;
                end else if (int_pending_q) begin
                    state_d       = ST_INT;
                    int_pending_d = 1'b0;
                end
            end else if (rom_last_step) begin
                // Always passes through IDLE, which guarantees a gap between sequences.
                state_d = ST_IDLE;
                step_d  = '0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.inj_valid     = rom_inj_valid;
        bus.inj_instr     = IW'(rom_inj_instr);
        bus.pc_hold       = (state_q != ST_IDLE);
        bus.busy          = (state_q != ST_IDLE);
        bus.pc_load       = rom_pc_load;
        bus.int_ack       = (state_q == ST_INT) && (step_q == '0);
        bus.pc_load_value = '0;
        if (rom_pc_load) begin
            bus.pc_load_value = (state_q == ST_INT) ? INT_VECTOR : PCW'(target_q);
        end
    end

endmodule

// File: tb/tb_inject_sequencer.sv
module tb_inject_sequencer;
    import inject_sequencer_pkg::*;

    localparam logic [31:0] VEC = 32'hDEAD_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inject_sequencer_if #(.IW(16), .PCW(32)) bus ();

    inject_sequencer #(.IW(16), .PCW(32), .INT_VECTOR(VEC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        inj_valid;
        logic [15:0] inj_instr;
        logic        pc_hold;
        logic        pc_load;
        logic [31:0] pc_load_value;
        logic        int_ack;
        logic        busy;
    } exp_t;

    typedef enum int {K_CALL, K_RET, K_RTI, K_INT} kind_e;

    typedef struct {
        kind_e       kind;
        logic [15:0] rdst;
        int          busy_len;
        string       name;
    } vec_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    busy_cnt = 0;
    string cur_name = "reset";

    function automatic exp_t idle_e();
        exp_t e = '0;
        return e;
    endfunction

    function automatic exp_t inj(logic [15:0] op);
        exp_t e = '0;
        e.inj_valid = 1'b1;
        e.inj_instr = op;
        e.pc_hold   = 1'b1;
        e.busy      = 1'b1;
        return e;
    endfunction

    function automatic exp_t ld(logic [31:0] v);
        exp_t e = '0;
        e.pc_load       = 1'b1;
        e.pc_load_value = v;
        e.pc_hold       = 1'b1;
        e.busy          = 1'b1;
        return e;
    endfunction

    task automatic push_seq(kind_e k, logic [15:0] t);
        exp_t e;
        case (k)
            K_CALL: begin
                sb.push_back(inj(OP_PUSH_PC_HI));
                sb.push_back(inj(OP_PUSH_PC_LO));
                sb.push_back(ld({16'h0000, t}));
            end
            K_RET: begin
                sb.push_back(inj(OP_POP_PC_LO));
                sb.push_back(inj(OP_POP_PC_HI));
                sb.push_back(inj(OP_NOP));
                sb.push_back(inj(OP_NOP));
            end
            K_RTI: begin
                sb.push_back(inj(OP_POP_CCR));
                sb.push_back(inj(OP_POP_PC_LO));
                sb.push_back(inj(OP_POP_PC_HI));
                sb.push_back(inj(OP_NOP));
                sb.push_back(inj(OP_NOP));
            end
            default: begin
                e = inj(OP_PUSH_PC_HI);
                e.int_ack = 1'b1;
                sb.push_back(e);
                sb.push_back(inj(OP_PUSH_PC_LO));
                sb.push_back(inj(OP_PUSH_CCR));
                sb.push_back(ld(VEC));
            end
        endcase
    endtask

    // Called at a negedge: drives the request and queues its expected outputs.
    task automatic issue(kind_e k, logic [15:0] t);
        case (k)
            K_CALL: begin bus.call_req = 1'b1; bus.rdst_value = t; end
            K_RET:  bus.ret_req = 1'b1;
            K_RTI:  bus.rti_req = 1'b1;
            default: begin
                bus.int_flag = 1'b1;
                sb.push_back(idle_e());   // edge registers first, INT starts one cycle later
            end
        endcase
        push_seq(k, t);
    endtask

    task automatic clear_reqs();
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;
        bus.rti_req  = 1'b0;
        bus.int_flag = 1'b0;
    endtask

    task automatic tick();
        exp_t e;
        exp_t a;
        @(negedge clk);
        e = idle_e();
        if (sb.size() != 0) e = sb.pop_front();
        a = {bus.inj_valid, bus.inj_instr, bus.pc_hold, bus.pc_load,
             bus.pc_load_value, bus.int_ack, bus.busy};
        if (bus.busy) busy_cnt++;
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: outputs got %h expected %h (vld,instr,hold,load,value,ack,busy)",
                     cur_name, a, e);
        end
    endtask

    task automatic drain();
        while (sb.size() != 0) tick();
    endtask

    task automatic check_busy(int start, int want);
        checks++;
        if (busy_cnt - start != want) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", cur_name, busy_cnt - start, want);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   b0;

        tbl[0] = '{K_CALL, 16'h0123, 3, "call_0123"};
        tbl[1] = '{K_RET,  16'h0000, 4, "ret"};
        tbl[2] = '{K_RTI,  16'h0000, 5, "rti"};
        tbl[3] = '{K_CALL, 16'hFFFF, 3, "call_ffff"};
        tbl[4] = '{K_INT,  16'h0000, 4, "int_alone"};
        tbl[5] = '{K_CALL, 16'h8000, 3, "call_8000"};
        tbl[6] = '{K_RTI,  16'h0000, 5, "rti_again"};

        reset          = 1'b0;
        bus.stall_in   = 1'b0;
        bus.rdst_value = 16'h0000;
        clear_reqs();

        // Reset state.
        cur_name = "reset";
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Table-driven single sequences; rdst changes after acceptance to prove capture.
        foreach (tbl[i]) begin
            cur_name = tbl[i].name;
            b0 = busy_cnt;
            issue(tbl[i].kind, tbl[i].rdst);
            tick();
            clear_reqs();
            bus.rdst_value = ~tbl[i].rdst;
            drain();
            tick();
            tick();
            check_busy(b0, tbl[i].busy_len);
        end

        // Request held during stall in IDLE is not accepted until stall drops.
        cur_name = "stall_idle";
        bus.stall_in = 1'b1;
        bus.ret_req  = 1'b1;
        sb.push_back(idle_e());
        sb.push_back(idle_e());
        push_seq(K_RET, 16'h0);
        tick();
        tick();
        bus.stall_in = 1'b0;
        tick();
        clear_reqs();
        drain();
        tick();

        // Stall for 3 cycles in RET step 1: outputs frozen, 7 busy cycles total.
        cur_name = "stall_ret";
        b0 = busy_cnt;
        bus.ret_req = 1'b1;
        sb.push_back(inj(OP_POP_PC_LO));
        repeat (4) sb.push_back(inj(OP_POP_PC_HI));
        sb.push_back(inj(OP_NOP));
        sb.push_back(inj(OP_NOP));
        tick();
        clear_reqs();
        tick();
        bus.stall_in = 1'b1;
        tick();
        tick();
        tick();
        bus.stall_in = 1'b0;
        drain();
        tick();
        check_busy(b0, 7);

        // Held ret_req: back-to-back RETs separated by exactly one IDLE cycle.
        cur_name = "ret_back2back";
        bus.ret_req = 1'b1;
        push_seq(K_RET, 16'h0);
        sb.push_back(idle_e());
        push_seq(K_RET, 16'h0);
        repeat (6) tick();
        clear_reqs();
        drain();
        tick();

        // Int edge during CALL step 0, second edge during CALL dropped.
        cur_name = "int_during_call";
        b0 = busy_cnt;
        issue(K_CALL, 16'h0123);
        sb.push_back(idle_e());
        push_seq(K_INT, 16'h0);
        tick();
        clear_reqs();
        bus.int_flag = 1'b1;
        tick();
        bus.int_flag = 1'b0;
        tick();
        bus.int_flag = 1'b1;
        tick();
        tick();
        bus.int_flag = 1'b0;
        drain();
        repeat (4) tick();
        check_busy(b0, 7);

        // RET and int edge together: RET first, one IDLE, then INT.
        cur_name = "ret_vs_int";
        bus.ret_req  = 1'b1;
        bus.int_flag = 1'b1;
        push_seq(K_RET, 16'h0);
        sb.push_back(idle_e());
        push_seq(K_INT, 16'h0);
        tick();
        clear_reqs();
        drain();
        repeat (2) tick();

        // Reset mid-RTI with an interrupt pending: everything idles afterwards.
        cur_name = "reset_mid_rti";
        issue(K_RTI, 16'h0);
        tick();
        clear_reqs();
        tick();
        bus.int_flag = 1'b1;
        tick();
        reset        = 1'b0;
        bus.int_flag = 1'b0;
        sb.delete();
        tick();
        reset = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
